// File: rtl/itch_msg_framer_pkg.sv
// Shared ITCH framing definitions: length-prefix size, message type codes and framer states.
package itch_msg_framer_pkg;

    localparam int ITCH_LEN_BYTES = 2;

    localparam logic [7:0] ITCH_TYPE_ADD_ORDER      = 8'h41;  // 'A'
    localparam logic [7:0] ITCH_TYPE_ORDER_DELETE   = 8'h44;  // 'D'
    localparam logic [7:0] ITCH_TYPE_ORDER_EXECUTED = 8'h45;  // 'E'
    localparam logic [7:0] ITCH_TYPE_SYSTEM_EVENT   = 8'h53;  // 'S'

    typedef enum logic [1:0] {
        LEN_HI,
        LEN_LO,
        BODY,
        DROP
    } itchFramerStateType;

endpackage

// File: rtl/itch_msg_framer.sv
// Splits a MoldUDP64 payload stream (2-byte BE length + body) into framed ITCH messages
// with start/end markers, type, length, error pulse and a completed-message count.
module itch_msg_framer
    import itch_msg_framer_pkg::*;
#(
    parameter int MAX_MSG_LEN  = 64,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic [7:0]  itchDataIn,
    input  logic        itchDataValidIn,
    output logic [7:0]  msgDataOut,
    output logic        msgValidOut,
    output logic        msgStartOut,
    output logic        msgEndOut,
    output logic [7:0]  msgTypeOut,
    output logic [15:0] msgLenOut,
    output logic        msgErrOut,
    output logic [31:0] msgCntOut
);

    localparam logic [15:0] MAX_LEN     = 16'(MAX_MSG_LEN);
    localparam logic [7:0]  TIMEOUT_VAL = 8'(IDLE_TIMEOUT);

    itchFramerStateType stateReg, stateNext;
    logic [7:0]  lenHiReg, lenHiNext;
    logic [15:0] remainingReg, remainingNext;
    logic [7:0]  idleTimerReg, idleTimerNext;

    logic [7:0]  dataNext;
    logic        validNext, startNext, endNext, errNext;
    logic [7:0]  typeNext;
    logic [15:0] lenOutNext;
    logic [31:0] cntNext;

    logic [15:0] lenWord;
    logic        timeoutHit;

    assign lenWord    = {lenHiReg, itchDataIn};
    // The timer only runs mid-message; a valid byte on the would-be timeout cycle wins.
    assign timeoutHit = (stateReg != LEN_HI) && !itchDataValidIn
                        && ((idleTimerReg + 8'd1) == TIMEOUT_VAL);

    always_comb begin
        stateNext     = stateReg;
        lenHiNext     = lenHiReg;
        remainingNext = remainingReg;
        idleTimerNext = idleTimerReg;
        dataNext      = msgDataOut;
        validNext     = 1'b0;
        startNext     = 1'b0;
        endNext       = 1'b0;
        errNext       = 1'b0;
        typeNext      = msgTypeOut;
        lenOutNext    = msgLenOut;
        cntNext       = msgCntOut;

        if (itchDataValidIn || stateReg == LEN_HI || timeoutHit) begin
            idleTimerNext = 8'd0;
        end else begin
            idleTimerNext = idleTimerReg + 8'd1;
        end

        unique case (stateReg)
            LEN_HI: begin
                if (itchDataValidIn) begin
                    lenHiNext = itchDataIn;
                    stateNext = LEN_LO;
                end
            end
            LEN_LO: begin
                if (itchDataValidIn) begin
                    if (lenWord == 16'd0) begin
                        errNext   = 1'b1;
                        stateNext = LEN_HI;
                    end else if (lenWord > MAX_LEN) begin
                        errNext       = 1'b1;
                        remainingNext = lenWord;
                        stateNext     = DROP;
                    end else begin
                        lenOutNext    = lenWord;
                        remainingNext = lenWord;
                        stateNext     = BODY;
                    end
                end else if (timeoutHit) begin
                    errNext   = 1'b1;
                    stateNext = LEN_HI;
                end
            end
            BODY: begin
                if (itchDataValidIn) begin
                    validNext     = 1'b1;
                    dataNext      = itchDataIn;
                    remainingNext = remainingReg - 16'd1;
                    // msgLenOut was latched with the accepted length, so equality marks byte one.
                    if (remainingReg == msgLenOut) begin
                        startNext = 1'b1;
                        typeNext  = itchDataIn;
                    end
                    if (remainingReg == 16'd1) begin
                        endNext   = 1'b1;
                        cntNext   = msgCntOut + 32'd1;
                        stateNext = LEN_HI;
                    end
                end else if (timeoutHit) begin
                    errNext   = 1'b1;
                    stateNext = LEN_HI;
                end
            end
            DROP: begin
                if (itchDataValidIn) begin
                    remainingNext = remainingReg - 16'd1;
                    if (remainingReg == 16'd1) begin
                        stateNext = LEN_HI;
                    end
                end else if (timeoutHit) begin
                    errNext   = 1'b1;
                    stateNext = LEN_HI;
                end
            end
            default: stateNext = LEN_HI;
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            stateReg     <= LEN_HI;
            lenHiReg     <= 8'd0;
            remainingReg <= 16'd0;
            idleTimerReg <= 8'd0;
            msgDataOut   <= 8'd0;
            msgValidOut  <= 1'b0;
            msgStartOut  <= 1'b0;
            msgEndOut    <= 1'b0;
            msgTypeOut   <= 8'd0;
            msgLenOut    <= 16'd0;
            msgErrOut    <= 1'b0;
            msgCntOut    <= 32'd0;
        end else begin
            stateReg     <= stateNext;
            lenHiReg     <= lenHiNext;
            remainingReg <= remainingNext;
            idleTimerReg <= idleTimerNext;
            msgDataOut   <= dataNext;
            msgValidOut  <= validNext;
            msgStartOut  <= startNext;
            msgEndOut    <= endNext;
            msgTypeOut   <= typeNext;
            msgLenOut    <= lenOutNext;
            msgErrOut    <= errNext;
            msgCntOut    <= cntNext;
        end
    end

endmodule

// File: doc/itch_msg_framer.md
# itch_msg_framer

Splits the ITCH payload byte stream from the Ethernet/IP/UDP/MoldUDP64 header parser into individual ITCH messages. MoldUDP64 message blocks arrive as a 2-byte big-endian length followed by that many message bytes. The block strips the length prefix and emits message bytes with start/end markers, the message type, the length and error flags. It sits directly downstream of the header parser and feeds the per-message-type ITCH decoders.

## Interface
Parameters:
- `MAX_MSG_LEN`, default 64: largest accepted message length in bytes. Longer messages are dropped.
- `IDLE_TIMEOUT`, default 8: number of consecutive cycles without valid data, mid-message, that aborts the message. Range 1–255.

Ports:
- `clkIn`  in  1  — single clock.
- `rstIn`  in  1  — synchronous, active-high reset.
- `itchDataIn`  in  8  — payload byte from the header parser.
- `itchDataValidIn`  in  1  — `itchDataIn` is valid this cycle. No backpressure.
- `msgDataOut`  out  8  — message body byte; the length prefix is never output.
- `msgValidOut`  out  1  — `msgDataOut` is valid.
- `msgStartOut`  out  1  — first body byte (the type byte) of a message.
- `msgEndOut`  out  1  — last body byte of a message.
- `msgTypeOut`  out  8  — type byte of the current message; held until the next start.
- `msgLenOut`  out  16  — length of the current message; held until the next accepted length.
- `msgErrOut`  out  1  — one-cycle pulse on a framing error.
- `msgCntOut`  out  32  — count of completed messages; wraps at 2^32.

## Operation
- States:
  - `LEN_HI`: reset and idle state.
  - `LEN_LO`
  - `BODY`
  - `DROP`
- `LEN_HI`: on a valid byte, store it as `len[15:8]` and go to `LEN_LO`.
- `LEN_LO`: on a valid byte, form `len = {hi, byte}`.
  - `len == 0`: pulse `msgErrOut`, go to `LEN_HI`.
  - `len > MAX_MSG_LEN`: pulse `msgErrOut`, set `remaining = len`, go to `DROP`.
  - Otherwise: latch `msgLenOut = len`, set `remaining = len`, go to `BODY`.
- `BODY`: each valid byte is output and decrements `remaining`.
  - The first body byte asserts `msgStartOut` and loads `msgTypeOut`.
  - The byte with `remaining == 1` asserts `msgEndOut`, increments `msgCntOut` and returns the FSM to `LEN_HI`.
- `DROP`: valid bytes are consumed with no output and decrement `remaining`. Return to `LEN_HI` after the byte with `remaining == 1`.
- Idle timer (8 bits):
  - Clears on any valid byte, and while in `LEN_HI`.
  - Otherwise increments on each cycle without valid data.
  - On reaching `IDLE_TIMEOUT` in `LEN_LO`, `BODY` or `DROP`: pulse `msgErrOut` and go to `LEN_HI`. No `msgEndOut` is emitted; consumers discard the partial message on `msgErrOut`.
- Arithmetic: `remaining` is 16 bits, decremented only in `BODY` or `DROP`, and never underflows (the exit happens at 1). `msgCntOut` is 32-bit modulo.

## Timing
- All outputs are registered. Latency from an input byte to the matching output is exactly 1 cycle.
- Reset values: all 1-bit outputs 0, `msgDataOut` 0, `msgTypeOut` 0, `msgLenOut` 0, `msgCntOut` 0; FSM in `LEN_HI`, timer 0, `remaining` 0.
- Reset mid-message: outputs are at reset values on the cycle after `rstIn` is sampled high. No `msgEndOut` or `msgErrOut` is emitted for the aborted message.
- A 1-byte message asserts `msgStartOut`, `msgEndOut` and `msgValidOut` in the same cycle.
- Back-to-back messages: the length bytes of message N+1 may immediately follow the last byte of message N. This creates a 2-cycle `msgValidOut` gap, with no lost bytes.
- Gaps shorter than `IDLE_TIMEOUT` inside a message are tolerated. The output gaps mirror the input gaps.
- A valid byte on the cycle the timer would reach `IDLE_TIMEOUT`: the byte wins. The timer clears and the byte is processed normally.
- `msgErrOut` is never asserted in the same cycle as `msgValidOut`.

## Structure
- Shared package `pkg` holds:
  - `ITCH_LEN_BYTES` (2) and the ITCH message-type codes used by downstream decoders (e.g. `'A'` = 8'h41, `'D'` = 8'h44, `'E'` = 8'h45).
  - A state enum `itchFramerStateType` for `LEN_HI`, `LEN_LO`, `BODY`, `DROP`.
- Single module. The FSM, idle timer and counters are small enough that no sub-module is warranted.

## Test plan
- Single message: bytes `00 03 41 AA BB` →
  - Output `41, AA, BB` on 3 consecutive cycles, 1 cycle after input.
  - `msgStartOut` on `41`, `msgEndOut` on `BB`.
  - `msgTypeOut = 41`, `msgLenOut = 3`, `msgCntOut = 1`.
- Back-to-back messages `00 01 44 00 02 45 CC` →
  - Message 1: 1-byte message with start and end on `44`.
  - Message 2: start on `45`, end on `CC`.
  - `msgCntOut = 2`, no `msgErrOut`.
- Zero and oversize lengths:
  - `00 00` → `msgErrOut` pulse, no output.
  - Then `00 50` followed by 80 bytes → `msgErrOut` pulse, all 80 bytes dropped.
  - A following `00 01 41` is framed normally.
- Truncation: `00 05 41 11` then `itchDataValidIn` low for 8 cycles → `msgErrOut` pulse, no `msgEndOut`. Next `00 01 44` frames correctly.
- Gap tolerance: `00 02 41`, then valid low for 7 cycles, then `22` → no error, end on `22`.
- Reset mid-message: assert `rstIn` during the body of a `00 04` message → next cycle all outputs are 0, the FSM is in `LEN_HI`, and `msgCntOut = 0`.
